// File: rtl/vga_vram_arbiter.sv
// Single-port character RAM owner for the VGA text display.
// Arbitrates display reads, a screen-clear sequencer and buffered CPU writes.
module vga_vram_arbiter #(
    parameter int              ADDR_W = 12,
    parameter int              DATA_W = 8,
    parameter int              CELLS  = 2400,
    parameter logic [DATA_W-1:0] BLANK = 8'h20
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              wr_oob,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // state | meaning
    // IDLE  | display reads and CPU buffer drains share the RAM
    // CLEAR | sequencer writes BLANK to every cell; CPU buffer is held
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(CELLS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                buf_full_q, buf_full_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic                wr_oob_q, wr_oob_d;
    logic                disp_valid_q;
    logic                oob_q;

    logic disp_oob;
    logic buf_oob;
    logic drain;
    logic accept;

    assign disp_oob = (disp_addr >= CELLS_A);
    assign buf_oob  = (buf_addr_q >= CELLS_A);
    assign drain    = (state_q == IDLE) && buf_full_q && !disp_req;
    assign accept   = cpu_wr_valid && !buf_full_q;

    // RAM port follows the arbitration decision in the same cycle
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (rst) begin
            if (disp_req) begin
                ram_en   = !disp_oob;
                ram_addr = disp_addr;
            end else if (state_q == CLEAR) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_ptr_q;
                ram_wdata = BLANK;
            end else if (buf_full_q) begin
                ram_en    = !buf_oob;
                ram_we    = !buf_oob;
                ram_addr  = buf_addr_q;
                ram_wdata = buf_data_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                if (!disp_req) begin
                    if (clr_ptr_q == LAST_A) begin
                        state_d   = IDLE;
                        clr_ptr_d = '0;
                    end else begin
                        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Drain and accept are mutually exclusive: one needs the buffer full, the other empty
    always_comb begin
        buf_full_d = buf_full_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        wr_oob_d   = wr_oob_q;
        if (drain) begin
            buf_full_d = 1'b0;
            if (buf_oob) begin
                wr_oob_d = 1'b1;
            end
        end
        if (accept) begin
            buf_full_d = 1'b1;
            buf_addr_d = cpu_wr_addr;
            buf_data_d = cpu_wr_data;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            clr_ptr_q    <= '0;
            buf_full_q   <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            wr_oob_q     <= 1'b0;
            disp_valid_q <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            buf_full_q   <= buf_full_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            wr_oob_q     <= wr_oob_d;
            disp_valid_q <= disp_req;
            oob_q        <= disp_req && disp_oob;
        end
    end

    always_comb begin
        disp_data = '0;
        if (disp_valid_q) begin
            disp_data = oob_q ? BLANK : ram_rdata;
        end
    end

    assign disp_valid   = disp_valid_q;
    assign cpu_wr_ready = !buf_full_q;
    assign clr_busy     = (state_q == CLEAR);
    assign wr_oob       = wr_oob_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: directed vector table, clear/reset sequences,
// then random traffic against a cell-level model of RAM contents and the write buffer.
module tb_vga_vram_arbiter;

    logic        vga_clk;
    logic        rst;
    logic        disp_req;
    logic [11:0] disp_addr;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [11:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        clr_start;
    logic        clr_busy;
    logic        wr_oob;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    vga_vram_arbiter dut (
        .vga_clk      (vga_clk),
        .rst          (rst),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_valid   (disp_valid),
        .disp_data    (disp_data),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .clr_start    (clr_start),
        .clr_busy     (clr_busy),
        .wr_oob       (wr_oob),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Synchronous-read single-port RAM; cell i starts as i ^ 8'h5A
    logic [7:0] mem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
        ram_rdata = 8'h00;
    end
    always @(posedge vga_clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req     = 1'b0;
        disp_addr    = '0;
        cpu_wr_valid = 1'b0;
        cpu_wr_addr  = '0;
        cpu_wr_data  = '0;
        clr_start    = 1'b0;
    endtask

    task automatic read_check(input logic [11:0] a, input logic [7:0] exp, input string nm);
        disp_req  = 1'b1;
        disp_addr = a;
        tick();
        disp_req = 1'b0;
        @(negedge vga_clk);
        chk({nm, "_valid"}, 32'(disp_valid), 32'd1);
        chk({nm, "_data"}, 32'(disp_data), 32'(exp));
        tick();
    endtask

    typedef struct {
        logic        rst_n;
        logic        dreq;
        logic [11:0] daddr;
        logic        cv;
        logic [11:0] caddr;
        logic [7:0]  cdata;
        logic        ready;
        logic        en;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic        dv;
        logic [7:0]  dd;
        logic        oob;
    } vec_t;

    vec_t vt [20];

    int busy_cnt, ptr, bad, nrdy, guard, rd_cnt, req_cnt, en_cnt;

    // random-phase model state
    logic [7:0]  shadow [0:2399];
    logic        pend, exp_dv, exp_oob, rdy;
    logic [11:0] pa;
    logic [7:0]  pd, exp_dd;
    logic        x_en, x_we;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();

        //          rst dreq daddr cv caddr cdata    | rdy en we addr wdata  dv dd     oob
        vt[0]  = '{1'b0,1'b0,12'd0,   1'b0,12'd0,   8'h00, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b0,8'h00,1'b0};
        vt[1]  = '{1'b0,1'b0,12'd0,   1'b0,12'd0,   8'h00, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b0,8'h00,1'b0};
        vt[2]  = '{1'b0,1'b0,12'd0,   1'b0,12'd0,   8'h00, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b0,8'h00,1'b0};
        vt[3]  = '{1'b1,1'b0,12'd0,   1'b1,12'd5,   8'h41, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b0,8'h00,1'b0};
        vt[4]  = '{1'b1,1'b0,12'd0,   1'b0,12'd0,   8'h00, 1'b0,1'b1,1'b1,12'd5, 8'h41,1'b0,8'h00,1'b0};
        vt[5]  = '{1'b1,1'b0,12'd0,   1'b0,12'd0,   8'h00, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b0,8'h00,1'b0};
        vt[6]  = '{1'b1,1'b1,12'd5,   1'b0,12'd0,   8'h00, 1'b1,1'b1,1'b0,12'd5, 8'h00,1'b0,8'h00,1'b0};
        vt[7]  = '{1'b1,1'b0,12'd0,   1'b0,12'd0,   8'h00, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b1,8'h41,1'b0};
        vt[8]  = '{1'b1,1'b0,12'd0,   1'b1,12'd10,  8'h77, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b0,8'h00,1'b0};
        vt[9]  = '{1'b1,1'b1,12'd1,   1'b0,12'd0,   8'h00, 1'b0,1'b1,1'b0,12'd1, 8'h00,1'b0,8'h00,1'b0};
        vt[10] = '{1'b1,1'b1,12'd2,   1'b0,12'd0,   8'h00, 1'b0,1'b1,1'b0,12'd2, 8'h00,1'b1,8'h5B,1'b0};
        vt[11] = '{1'b1,1'b1,12'd3,   1'b0,12'd0,   8'h00, 1'b0,1'b1,1'b0,12'd3, 8'h00,1'b1,8'h58,1'b0};
        vt[12] = '{1'b1,1'b0,12'd0,   1'b0,12'd0,   8'h00, 1'b0,1'b1,1'b1,12'd10,8'h77,1'b1,8'h59,1'b0};
        vt[13] = '{1'b1,1'b0,12'd0,   1'b0,12'd0,   8'h00, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b0,8'h00,1'b0};
        vt[14] = '{1'b1,1'b0,12'd0,   1'b1,12'd2400,8'h33, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b0,8'h00,1'b0};
        vt[15] = '{1'b1,1'b0,12'd0,   1'b0,12'd0,   8'h00, 1'b0,1'b0,1'b0,12'd0, 8'h00,1'b0,8'h00,1'b0};
        vt[16] = '{1'b1,1'b1,12'd4000,1'b0,12'd0,   8'h00, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b0,8'h00,1'b1};
        vt[17] = '{1'b1,1'b0,12'd0,   1'b0,12'd0,   8'h00, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b1,8'h20,1'b1};
        vt[18] = '{1'b1,1'b1,12'd10,  1'b0,12'd0,   8'h00, 1'b1,1'b1,1'b0,12'd10,8'h00,1'b0,8'h00,1'b1};
        vt[19] = '{1'b1,1'b0,12'd0,   1'b0,12'd0,   8'h00, 1'b1,1'b0,1'b0,12'd0, 8'h00,1'b1,8'h77,1'b1};

        for (int r = 0; r < 20; r++) begin
            rst          = vt[r].rst_n;
            disp_req     = vt[r].dreq;
            disp_addr    = vt[r].daddr;
            cpu_wr_valid = vt[r].cv;
            cpu_wr_addr  = vt[r].caddr;
            cpu_wr_data  = vt[r].cdata;
            @(negedge vga_clk);
            chk($sformatf("vec%0d_ready", r), 32'(cpu_wr_ready), 32'(vt[r].ready));
            chk($sformatf("vec%0d_en", r), 32'(ram_en), 32'(vt[r].en));
            chk($sformatf("vec%0d_we", r), 32'(ram_we), 32'(vt[r].we));
            if (vt[r].en) chk($sformatf("vec%0d_addr", r), 32'(ram_addr), 32'(vt[r].addr));
            if (vt[r].we) chk($sformatf("vec%0d_wdata", r), 32'(ram_wdata), 32'(vt[r].wdata));
            chk($sformatf("vec%0d_dv", r), 32'(disp_valid), 32'(vt[r].dv));
            chk($sformatf("vec%0d_dd", r), 32'(disp_data), 32'(vt[r].dd));
            chk($sformatf("vec%0d_oob", r), 32'(wr_oob), 32'(vt[r].oob));
            chk($sformatf("vec%0d_busy", r), 32'(clr_busy), 32'd0);
            tick();
        end
        idle_inputs();

        // Full clear with a CPU write accepted alongside clr_start and a clr_start repeated mid-clear
        clr_start    = 1'b1;
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 12'd7;
        cpu_wr_data  = 8'h99;
        @(negedge vga_clk);
        chk("clr_pre_ready", 32'(cpu_wr_ready), 32'd1);
        chk("clr_pre_busy", 32'(clr_busy), 32'd0);
        tick();
        idle_inputs();
        busy_cnt = 0; ptr = 0; bad = 0; nrdy = 0; guard = 0;
        while (clr_busy && guard < 3000) begin
            clr_start = (busy_cnt == 50);
            @(negedge vga_clk);
            busy_cnt++;
            if (cpu_wr_ready) nrdy++;
            if (ram_en && ram_we) begin
                if (ram_addr != ptr[11:0] || ram_wdata != 8'h20) bad++;
                ptr++;
            end
            tick();
            guard++;
        end
        clr_start = 1'b0;
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd2400);
        chk("clr_write_count", 32'(ptr), 32'd2400);
        chk("clr_write_seq_errors", 32'(bad), 32'd0);
        chk("clr_ready_during", 32'(nrdy), 32'd0);
        @(negedge vga_clk);
        chk("clr_drain_we", 32'(ram_we), 32'd1);
        chk("clr_drain_addr", 32'(ram_addr), 32'd7);
        chk("clr_drain_data", 32'(ram_wdata), 32'h99);
        tick();
        read_check(12'd7, 8'h99, "clr_rd7");
        read_check(12'd8, 8'h20, "clr_rd8");

        // Clear interleaved with display reads every other cycle
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 12'd2399;
        cpu_wr_data  = 8'h66;
        tick();
        cpu_wr_valid = 1'b0;
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_cnt = 0; bad = 0; rd_cnt = 0; req_cnt = 0; guard = 0;
        while (clr_busy && guard < 6000) begin
            disp_req  = (busy_cnt % 2 == 0);
            disp_addr = 12'd2399;
            @(negedge vga_clk);
            if (disp_req) req_cnt++;
            if (disp_valid) begin
                rd_cnt++;
                if (disp_data != 8'h66) bad++;
            end
            busy_cnt++;
            tick();
            guard++;
        end
        disp_req = 1'b0;
        @(negedge vga_clk);
        if (disp_valid) rd_cnt++;
        tick();
        chk("clrrd_busy_cycles", 32'(busy_cnt), 32'd4800);
        chk("clrrd_reads_returned", 32'(rd_cnt), 32'(req_cnt));
        chk("clrrd_req_count", 32'(req_cnt), 32'd2400);
        chk("clrrd_data_errors", 32'(bad), 32'd0);
        read_check(12'd2399, 8'h20, "clrrd_last");

        // Reset in the middle of a clear with a write held in the buffer
        clr_start = 1'b1;
        tick();
        clr_start    = 1'b0;
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 12'd9;
        cpu_wr_data  = 8'hAB;
        @(negedge vga_clk);
        chk("rstclr_accept_ready", 32'(cpu_wr_ready), 32'd1);
        tick();
        cpu_wr_valid = 1'b0;
        repeat (99) tick();
        #1;
        chk("rstclr_ptr_addr", 32'(ram_addr), 32'd100);
        chk("rstclr_ptr_we", 32'(ram_we), 32'd1);
        rst = 1'b0;
        @(negedge vga_clk);
        chk("rstclr_en_forced", 32'(ram_en), 32'd0);
        chk("rstclr_we_forced", 32'(ram_we), 32'd0);
        tick();
        rst = 1'b1;
        @(negedge vga_clk);
        chk("rstclr_busy", 32'(clr_busy), 32'd0);
        chk("rstclr_ready", 32'(cpu_wr_ready), 32'd1);
        chk("rstclr_oob", 32'(wr_oob), 32'd0);
        tick();
        en_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge vga_clk);
            if (ram_en) en_cnt++;
            tick();
        end
        chk("rstclr_no_access", 32'(en_cnt), 32'd0);
        read_check(12'd9, 8'h20, "rstclr_lost_write");

        // Random traffic against a cell-level model: the held write commits
        // in the first cycle without a display read
        for (int i = 0; i < 2400; i++) shadow[i] = 8'h20;
        pend = 1'b0; pa = '0; pd = '0;
        exp_dv = 1'b0; exp_dd = '0; exp_oob = 1'b0;
        for (int c = 0; c < 800; c++) begin
            disp_req     = ($urandom_range(0, 2) == 0);
            disp_addr    = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(2400, 4095))
                                                        : 12'($urandom_range(0, 63));
            cpu_wr_valid = ($urandom_range(0, 1) == 1);
            cpu_wr_addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(2400, 4095))
                                                        : 12'($urandom_range(0, 63));
            cpu_wr_data  = 8'($urandom_range(0, 255));
            @(negedge vga_clk);
            x_we = !disp_req && pend && (pa < 12'd2400);
            x_en = disp_req ? (disp_addr < 12'd2400) : x_we;
            chk("rnd_ready", 32'(cpu_wr_ready), 32'(!pend));
            chk("rnd_en", 32'(ram_en), 32'(x_en));
            chk("rnd_we", 32'(ram_we), 32'(x_we));
            if (x_en) chk("rnd_addr", 32'(ram_addr), disp_req ? 32'(disp_addr) : 32'(pa));
            if (x_we) chk("rnd_wdata", 32'(ram_wdata), 32'(pd));
            chk("rnd_dv", 32'(disp_valid), 32'(exp_dv));
            chk("rnd_dd", 32'(disp_data), exp_dv ? 32'(exp_dd) : 32'd0);
            chk("rnd_oob", 32'(wr_oob), 32'(exp_oob));
            rdy    = !pend;
            exp_dv = disp_req;
            exp_dd = (disp_addr < 12'd2400) ? shadow[disp_addr] : 8'h20;
            if (!disp_req && pend) begin
                if (pa < 12'd2400) shadow[pa] = pd;
                else               exp_oob = 1'b1;
                pend = 1'b0;
            end
            if (cpu_wr_valid && rdy) begin
                pend = 1'b1;
                pa   = cpu_wr_addr;
                pd   = cpu_wr_data;
            end
            tick();
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
